// File: rtl/bus_sw_pkg.sv
// Shared definitions for the A/B bus switching controller and its input arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   A_MAX_ADDR              : top address of region A, decoded in the switch
//   CNT_W                   : width of the arbiter's beat and stall counters
//   arb_state_e             : arbiter FSM states
package bus_sw_pkg;

    localparam int         ADDR_W_DEF = 8;
    localparam int         DATA_W_DEF = 16;
    localparam logic [7:0] A_MAX_ADDR = 8'h3F;
    localparam int         CNT_W      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_switch_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i   : request vector
//   ptr_i   : index with highest priority this round
//   found_o : at least one request is set
//   idx_o   : first set request at or after ptr_i, wrapping modulo N
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    int j;

    // Rotate, priority-encode and un-rotate folded into one scan: walking the
    // rotated offsets from the far end down to 0 leaves the closest hit last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_switch_arbiter.sv
// bus_switch_arbiter: round-robin arbiter feeding the single vld/addr/data
// input of the A/B bus switch. One requester owns the bus per grant; its beats
// are forwarded one cycle after the handshake.
//   clk, rstn          : clock, asynchronous active-low reset
//   req_vld/addr/data  : per-requester beats (packed, requester i at slice i)
//   req_last           : final beat of a burst
//   req_rdy            : accept, only ever to the current owner
//   bus_vld/addr/data  : registered beat towards the switch
//   gnt_id             : current or most recent owner
//   busy               : a grant is in progress
module bus_switch_arbiter
    import bus_sw_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int MAX_BURST = 8,
    parameter  int STALL_TO  = 4,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic                      bus_vld,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_data,
    output logic [IDX_W-1:0]          gnt_id,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TO - 1);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              bus_vld_q, bus_vld_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;

    logic              found;
    logic [IDX_W-1:0]  winner;
    logic              hs;
    logic              release_now;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_vld),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (winner)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            beat_q     <= '0;
            stall_q    <= '0;
            bus_vld_q  <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            beat_q     <= beat_d;
            stall_q    <= stall_d;
            bus_vld_q  <= bus_vld_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        beat_d      = beat_q;
        stall_d     = stall_q;
        // Bus outputs are zeroed on any cycle without a handshake, never held.
        bus_vld_d   = 1'b0;
        bus_addr_d  = '0;
        bus_data_d  = '0;
        req_rdy     = '0;
        hs          = 1'b0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                // No accept here: arbitration always costs one bubble cycle.
                if (found) begin
                    gnt_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_rdy[gnt_q] = req_vld[gnt_q];
                hs             = req_vld[gnt_q];
                if (hs) begin
                    bus_vld_d  = 1'b1;
                    bus_addr_d = req_addr[int'(gnt_q) * ADDR_W +: ADDR_W];
                    bus_data_d = req_data[int'(gnt_q) * DATA_W +: DATA_W];
                    beat_d     = beat_q + 8'd1;
                    stall_d    = '0;
                end else begin
                    stall_d    = stall_q + 8'd1;
                end
                release_now = (hs && (req_last[gnt_q] || beat_q == BEAT_LAST))
                           || (!hs && stall_q == STALL_LAST);
                if (release_now) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == IDX_TOP) ? '0 : gnt_q + 1'b1;
                    beat_d  = '0;
                    stall_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_vld  = bus_vld_q;
    assign bus_addr = bus_addr_q;
    assign bus_data = bus_data_q;
    assign gnt_id   = gnt_q;
    assign busy     = (state_q == GRANT);

endmodule
